// File: rtl/car_alarm_pkg.sv
// Shared definitions for the car alarm controller.
//   - 2-bit state encoding (DISARMED, ARMED, ENTRY, SIREN); the encoding is
//     visible on the AlarmState debug port, so it must not change.
//   - Default entry-delay / siren-time / counter-width constants.
//   - lightsLeftOn(): the lights-left-on warning condition.
package car_alarm_pkg;

   typedef logic [1:0] alarmState_t;

   localparam logic [1:0] DISARMED = 2'd0;
   localparam logic [1:0] ARMED    = 2'd1;
   localparam logic [1:0] ENTRY    = 2'd2;
   localparam logic [1:0] SIREN    = 2'd3;

   localparam int DEFAULT_ENTRY_DELAY = 8;
   localparam int DEFAULT_SIREN_TIME  = 16;
   localparam int DEFAULT_CNT_W       = 8;

   function automatic logic lightsLeftOn(input logic lightsOn,
                                         input logic doorOpen,
                                         input logic ignitionOn);
      return lightsOn & doorOpen & ~ignitionOn;
   endfunction

endpackage

// File: rtl/car_alarm_controller_timer.sv
// alarm_timer: down-counter shared by the ENTRY and SIREN phases.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   clear           synchronous clear to 0 (highest priority after reset)
//   load, loadValue load a new terminal count
//   decrement       count down by one; saturates at 0, never wraps
//   count           current counter value
//   done            terminal count reached (count == 0)
module alarm_timer
   import car_alarm_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] loadValue,
   input  logic             decrement,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (load) begin
         count <= loadValue;
      end else if (decrement && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/car_alarm_controller.sv
// car_alarm_controller: arm/disarm sequencing, entry-delay countdown, bounded
// siren drive and the registered lights-left-on warning.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   IgnitionSignalOn  ignition on
//   OpenDoorSign      any door open
//   CarLightsOnSign   headlights on
//   ArmRequest        one-cycle arm pulse from key fob
//   DisarmRequest     one-cycle disarm pulse from key fob
//   CarAlarmSignal    siren drive (high in SIREN)
//   ArmedIndicator    high in every state except DISARMED
//   EntryChirp        high in ENTRY
//   LightsWarning     registered lights & door & ~ignition
//   AlarmState        state register, for debug
//
// state    | meaning
// DISARMED | idle, counter held at 0
// ARMED    | watching door and ignition, counter held at 0
// ENTRY    | door opened while armed, counting down the entry delay
// SIREN    | siren on, counting down the siren time
module car_alarm_controller
   import car_alarm_pkg::*;
#(
   parameter int ENTRY_DELAY = DEFAULT_ENTRY_DELAY,
   parameter int SIREN_TIME  = DEFAULT_SIREN_TIME,
   parameter int CNT_W       = DEFAULT_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       IgnitionSignalOn,
   input  logic       OpenDoorSign,
   input  logic       CarLightsOnSign,
   input  logic       ArmRequest,
   input  logic       DisarmRequest,
   output logic       CarAlarmSignal,
   output logic       ArmedIndicator,
   output logic       EntryChirp,
   output logic       LightsWarning,
   output logic [1:0] AlarmState
);

   localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
   localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);

   alarmState_t      state;
   alarmState_t      nextState;
   logic             timerClear;
   logic             timerLoad;
   logic [CNT_W-1:0] timerLoadValue;
   logic             timerDec;
   logic [CNT_W-1:0] timerCount;
   logic             timerDone;

   alarm_timer #(
      .CNT_W (CNT_W)
   ) uTimer (
      .clk       (clk),
      .reset     (reset),
      .clear     (timerClear),
      .load      (timerLoad),
      .loadValue (timerLoadValue),
      .decrement (timerDec),
      .count     (timerCount),
      .done      (timerDone)
   );

   always_comb begin
      nextState      = state;
      timerClear     = 1'b0;
      timerLoad      = 1'b0;
      timerLoadValue = '0;
      timerDec       = 1'b0;

      if (DisarmRequest) begin
         // Disarm overrides arm and every timer-driven transition.
         nextState  = DISARMED;
         timerClear = 1'b1;
      end else begin
         case (state)
            DISARMED: begin
               timerClear = 1'b1;
               if (ArmRequest && !IgnitionSignalOn && !OpenDoorSign) begin
                  nextState = ARMED;
               end
            end
            ARMED: begin
               // Hot-wire beats a door opening.
               if (IgnitionSignalOn) begin
                  nextState      = SIREN;
                  timerLoad      = 1'b1;
                  timerLoadValue = SIREN_LOAD;
               end else if (OpenDoorSign) begin
                  nextState      = ENTRY;
                  timerLoad      = 1'b1;
                  timerLoadValue = ENTRY_LOAD;
               end
            end
            ENTRY: begin
               // Closing the door again does not cancel the countdown.
               if (IgnitionSignalOn || timerDone) begin
                  nextState      = SIREN;
                  timerLoad      = 1'b1;
                  timerLoadValue = SIREN_LOAD;
               end else begin
                  timerDec = 1'b1;
               end
            end
            default: begin
               if (timerDone) begin
                  nextState  = ARMED;
                  timerClear = 1'b1;
               end else begin
                  timerDec = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= DISARMED;
         LightsWarning <= 1'b0;
      end else begin
         state         <= nextState;
         LightsWarning <= lightsLeftOn(CarLightsOnSign, OpenDoorSign, IgnitionSignalOn);
      end
   end

   assign CarAlarmSignal = (state == SIREN);
   assign ArmedIndicator = (state != DISARMED);
   assign EntryChirp     = (state == ENTRY);
   assign AlarmState     = state;

endmodule

// File: tb/tb_car_alarm_controller.sv
module tb_car_alarm_controller;

   localparam int ENTRY_DELAY = 8;
   localparam int SIREN_TIME  = 16;
   localparam int CNT_W       = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       IgnitionSignalOn = 1'b0;
   logic       OpenDoorSign = 1'b0;
   logic       CarLightsOnSign = 1'b0;
   logic       ArmRequest = 1'b0;
   logic       DisarmRequest = 1'b0;
   logic       CarAlarmSignal;
   logic       ArmedIndicator;
   logic       EntryChirp;
   logic       LightsWarning;
   logic [1:0] AlarmState;

   int nAsserts = 0;
   int nFail    = 0;

   // Reference model: phase name plus "cycles left in this phase".
   typedef enum int {M_OFF, M_WATCH, M_GRACE, M_SCREAM} mode_t;
   mode_t mMode = M_OFF;
   int    mLeft = 0;
   logic  mLw   = 1'b0;

   car_alarm_controller #(
      .ENTRY_DELAY (ENTRY_DELAY),
      .SIREN_TIME  (SIREN_TIME),
      .CNT_W       (CNT_W)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .IgnitionSignalOn (IgnitionSignalOn),
      .OpenDoorSign     (OpenDoorSign),
      .CarLightsOnSign  (CarLightsOnSign),
      .ArmRequest       (ArmRequest),
      .DisarmRequest    (DisarmRequest),
      .CarAlarmSignal   (CarAlarmSignal),
      .ArmedIndicator   (ArmedIndicator),
      .EntryChirp       (EntryChirp),
      .LightsWarning    (LightsWarning),
      .AlarmState       (AlarmState)
   );

   always #5 clk = ~clk;

   task automatic modelStep(input logic r, input logic ign, input logic door,
                            input logic lights, input logic arm, input logic disarm);
      if (r) begin
         mMode = M_OFF; mLeft = 0; mLw = 1'b0;
      end else begin
         mLw = lights && door && !ign;
         if (disarm) begin
            mMode = M_OFF; mLeft = 0;
         end else begin
            case (mMode)
               M_OFF:   if (arm && !ign && !door) mMode = M_WATCH;
               M_WATCH: begin
                  if (ign)       begin mMode = M_SCREAM; mLeft = SIREN_TIME;  end
                  else if (door) begin mMode = M_GRACE;  mLeft = ENTRY_DELAY; end
               end
               M_GRACE: begin
                  if (ign) begin
                     mMode = M_SCREAM; mLeft = SIREN_TIME;
                  end else begin
                     mLeft = mLeft - 1;
                     if (mLeft == 0) begin mMode = M_SCREAM; mLeft = SIREN_TIME; end
                  end
               end
               M_SCREAM: begin
                  mLeft = mLeft - 1;
                  if (mLeft == 0) mMode = M_WATCH;
               end
               default: mMode = M_OFF;
            endcase
         end
      end
   endtask

   task automatic chk(input string tag, input int observed, input int expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag);
      int expCount;
      expCount = (mMode == M_GRACE || mMode == M_SCREAM) ? mLeft - 1 : 0;
      chk({tag, ".state"},  int'(AlarmState),     int'(mMode));
      chk({tag, ".siren"},  int'(CarAlarmSignal), int'(mMode == M_SCREAM));
      chk({tag, ".armed"},  int'(ArmedIndicator), int'(mMode != M_OFF));
      chk({tag, ".chirp"},  int'(EntryChirp),     int'(mMode == M_GRACE));
      chk({tag, ".lights"}, int'(LightsWarning),  int'(mLw));
      chk({tag, ".count"},  int'(dut.uTimer.count), expCount);
   endtask

   // Drive one cycle of inputs, advance the clock, update the model, compare.
   task automatic step(input string tag, input logic r, input logic ign,
                       input logic door, input logic lights, input logic arm,
                       input logic disarm);
      reset = r; IgnitionSignalOn = ign; OpenDoorSign = door;
      CarLightsOnSign = lights; ArmRequest = arm; DisarmRequest = disarm;
      @(posedge clk);
      #1;
      modelStep(r, ign, door, lights, arm, disarm);
      checkAll(tag);
   endtask

   initial begin
      int chirpCnt;
      int sirenCnt;

      // reset
      step("reset0", 1, 0, 0, 0, 0, 0);
      step("reset1", 1, 0, 0, 0, 0, 0);
      chk("resetState", int'(AlarmState), 0);
      chk("resetSiren", int'(CarAlarmSignal), 0);

      // arm
      step("arm", 0, 0, 0, 0, 1, 0);
      chk("armState", int'(AlarmState), 1);
      chk("armInd", int'(ArmedIndicator), 1);

      // door pulse: 8 chirp cycles, 16 siren cycles, back to ARMED
      step("doorPulse", 0, 0, 1, 0, 0, 0);
      chirpCnt = int'(EntryChirp);
      sirenCnt = int'(CarAlarmSignal);
      for (int i = 0; i < 30; i++) begin
         step("doorSeq", 0, 0, 0, 0, 0, 0);
         chirpCnt += int'(EntryChirp);
         sirenCnt += int'(CarAlarmSignal);
      end
      chk("chirpLen", chirpCnt, ENTRY_DELAY);
      chk("sirenLen", sirenCnt, SIREN_TIME);
      chk("backToArmed", int'(AlarmState), 1);

      // hot-wire: siren immediately, no ENTRY
      step("hotwire", 0, 1, 0, 0, 0, 0);
      chk("hotwireSiren", int'(CarAlarmSignal), 1);
      chk("hotwireNoChirp", int'(EntryChirp), 0);
      step("disarmSiren", 0, 0, 0, 0, 0, 1);

      // rejected arms
      step("armDoorOpen", 0, 0, 1, 0, 1, 0);
      chk("armDoorOpenState", int'(AlarmState), 0);
      step("idle", 0, 0, 0, 0, 0, 0);
      chk("noArmMemory", int'(AlarmState), 0);
      step("armAndDisarm", 0, 0, 0, 0, 1, 1);
      chk("armAndDisarmState", int'(AlarmState), 0);

      // disarm during 3rd ENTRY cycle
      step("arm2", 0, 0, 0, 0, 1, 0);
      step("door2", 0, 0, 1, 0, 0, 0);
      step("entry2", 0, 0, 0, 0, 0, 0);
      step("entry3", 0, 0, 0, 0, 0, 0);
      step("disarmEntry", 0, 0, 0, 0, 0, 1);
      chk("disarmEntryState", int'(AlarmState), 0);
      chk("disarmEntryCount", int'(dut.uTimer.count), 0);

      // disarm during SIREN
      step("arm3", 0, 0, 0, 0, 1, 0);
      step("hot3", 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step("siren3", 0, 0, 0, 0, 0, 0);
      step("disarmSiren3", 0, 0, 0, 0, 0, 1);
      chk("disarmSirenSiren", int'(CarAlarmSignal), 0);

      // same with reset, ENTRY then SIREN
      step("arm4", 0, 0, 0, 0, 1, 0);
      step("door4", 0, 0, 1, 0, 0, 0);
      step("entry4", 0, 0, 0, 0, 0, 0);
      step("entry4b", 0, 0, 0, 0, 0, 0);
      step("resetEntry", 1, 0, 0, 0, 0, 0);
      chk("resetEntryChirp", int'(EntryChirp), 0);
      for (int i = 0; i < 12; i++) step("afterResetEntry", 0, 0, 0, 0, 0, 0);
      step("arm5", 0, 0, 0, 0, 1, 0);
      step("hot5", 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step("siren5", 0, 0, 0, 0, 0, 0);
      step("resetSiren", 1, 0, 0, 0, 0, 0);
      chk("resetSirenSiren", int'(CarAlarmSignal), 0);
      for (int i = 0; i < 20; i++) step("afterResetSiren", 0, 0, 0, 0, 0, 0);

      // lights-left-on warning
      step("lightsOn", 0, 0, 1, 1, 0, 0);
      chk("lightsWarnOn", int'(LightsWarning), 1);
      step("ignOn", 0, 1, 1, 1, 0, 0);
      chk("lightsWarnOff", int'(LightsWarning), 0);

      // random traffic against the model
      step("preRand", 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3000; i++) begin
         step("rand",
              ($urandom_range(199) == 0),
              ($urandom_range(19) == 0),
              ($urandom_range(5) == 0),
              ($urandom_range(1) == 0),
              ($urandom_range(3) == 0),
              ($urandom_range(39) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
